branch_predictor: RTL and testbench

//   Dynamic branch predictor for the 5-stage MIPS pipeline.
//   - IF stage: looks up the fetch PC and returns a predicted direction and target.
//   - Memory stage: trains on resolved branches and jumps, and flags mispredicts
//     so the core flushes only when the prediction was wrong.

---
 rtl/branch_predictor_pkg.sv | 23 ++
 rtl/branch_predictor_sat_counter.sv | 40 ++++
 rtl/branch_predictor.sv | 107 ++++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants and width helpers for the branch predictor slice.
package bp_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

  function automatic int satMax(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int weakNt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int weakT(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter; load has priority over inc, inc over dec.
module sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic [CNT_W-1:0] cnt,
  output logic             msb
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(satMax(CNT_W));

  logic [CNT_W-1:0] cnt_r;

  // counter state with saturation at both ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt_r <= loadVal;
    end else if (inc && (cnt_r != MAX_VAL)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign msb = cnt_r[CNT_W-1];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_pred_taken,
  input  logic [ADDR_W-1:0] update_pred_target,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [31:0]       mispredict_cnt
);

  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic [CNT_W-1:0]  cntVal_s [ENTRIES];
  logic              cntMsb_s [ENTRIES];
  logic [31:0]       mispredictCnt_r;

  logic [IDX_W-1:0] lkIdx_s, updIdx_s;
  logic [TAG_W-1:0] lkTag_s, updTag_s;
  logic             lkHit_s, updHit_s, doUpd_s, alloc_s;

  assign lkIdx_s  = lookup_pc[IDX_W+1:2];
  assign lkTag_s  = lookup_pc[ADDR_W-1:IDX_W+2];
  assign updIdx_s = update_pc[IDX_W+1:2];
  assign updTag_s = update_pc[ADDR_W-1:IDX_W+2];

  // lookup, update decode and mispredict detection
  always_comb begin
    lkHit_s     = valid_r[lkIdx_s] && (tag_r[lkIdx_s] == lkTag_s);
    updHit_s    = valid_r[updIdx_s] && (tag_r[updIdx_s] == updTag_s);
    // flush suppresses every table change on its edge
    doUpd_s     = update_valid && !flush_all;
    alloc_s     = doUpd_s && !updHit_s && update_taken;
    pred_taken  = lkHit_s && cntMsb_s[lkIdx_s];
    if (pred_taken) begin
      pred_target = target_r[lkIdx_s];
    end else begin
      pred_target = lookup_pc + ADDR_W'(4);
    end
    mispredict  = update_valid && ((update_taken != update_pred_taken) ||
                  (update_taken && (update_target != update_pred_target)));
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : gEntry
    logic sel_s;
    assign sel_s = (updIdx_s == IDX_W'(i));

    sat_counter #(.CNT_W(CNT_W), .RST_VAL(weakNt(CNT_W))) uCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (doUpd_s && updHit_s && sel_s && update_taken),
      .dec     (doUpd_s && updHit_s && sel_s && !update_taken),
      .load    (alloc_s && sel_s),
      .loadVal (CNT_W'(weakT(CNT_W))),
      .cnt     (cntVal_s[i]),
      .msb     (cntMsb_s[i])
    );

    // valid, tag and target storage for this entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {ADDR_W{1'b0}};
      end else if (flush_all) begin
        valid_r[i]  <= 1'b0;
      end else if (doUpd_s && sel_s && update_taken) begin
        valid_r[i]  <= 1'b1;
        tag_r[i]    <= updTag_s;
        target_r[i] <= update_target;
      end else begin
        valid_r[i]  <= valid_r[i];
      end
    end
  end

  // saturating mispredict statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredictCnt_r <= 32'd0;
    end else if (mispredict && (mispredictCnt_r != 32'hFFFF_FFFF)) begin
      mispredictCnt_r <= mispredictCnt_r + 32'd1;
    end else begin
      mispredictCnt_r <= mispredictCnt_r;
    end
  end

  assign mispredict_cnt = mispredictCnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CNT_W=2).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        flush_all;
  logic        mispredict;
  logic [31:0] mispredict_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .ADDR_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lookup_pc          (lookup_pc),
    .pred_taken         (pred_taken),
    .pred_target        (pred_target),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .flush_all          (flush_all),
    .mispredict         (mispredict),
    .mispredict_cnt     (mispredict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic v, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    update_valid       = v;
    update_pc          = pc;
    update_taken       = tk;
    update_target      = tgt;
    update_pred_taken  = ptk;
    update_pred_target = ptgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic expTk, input logic [31:0] expTgt);
    lookup_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, expTk});
    check({tag, "_target"}, pred_target, expTgt);
  endtask

  initial begin
    rst_n = 1'b0;
    flush_all = 1'b0;
    lookup_pc = 32'h40;
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #12;
    // 1. reset state
    look("rst", 32'h40, 1'b0, 32'h44);
    check("rst_cnt", mispredict_cnt, 32'd0);
    check("rst_misp", {31'd0, mispredict}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 2. first taken update allocates; same-cycle lookup sees old state
    upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    look("same_cycle", 32'h40, 1'b0, 32'h44);
    check("alloc_misp", {31'd0, mispredict}, 32'd1);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("alloc", 32'h40, 1'b1, 32'h100);
    check("alloc_cnt", mispredict_cnt, 32'd1);

    // 3. training: three correct taken, target change, then two not-taken
    for (int k = 0; k < 3; k++) begin
      upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      #1;
      check("train_misp", {31'd0, mispredict}, 32'd0);
      tick();
    end
    check("train_cnt", mispredict_cnt, 32'd1);
    upd(1'b1, 32'h40, 1'b1, 32'h120, 1'b1, 32'h100);
    #1;
    check("tgt_misp", {31'd0, mispredict}, 32'd1);
    tick();
    upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h120);
    look("new_tgt", 32'h40, 1'b1, 32'h120);
    check("tgt_cnt", mispredict_cnt, 32'd2);
    tick();
    look("nt1", 32'h40, 1'b1, 32'h120);
    check("nt1_cnt", mispredict_cnt, 32'd3);
    tick();
    upd(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h304);
    look("nt2", 32'h40, 1'b0, 32'h44);
    check("nt2_cnt", mispredict_cnt, 32'd4);
    check("miss_nt_misp", {31'd0, mispredict}, 32'd0);
    tick();
    // counter is at 1: one taken update brings it to 2 (predict taken)
    upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    look("miss_nt", 32'h40, 1'b0, 32'h44);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("retrain", 32'h40, 1'b1, 32'h100);

    // 4. alias eviction at idx 0
    upd(1'b1, 32'h80, 1'b1, 32'h180, 1'b0, 32'h84);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("evicted", 32'h40, 1'b0, 32'h44);
    look("alias_hit", 32'h80, 1'b1, 32'h180);
    look("low_bits", 32'h82, 1'b1, 32'h180);
    look("other_idx", 32'h44, 1'b0, 32'h48);
    check("alias_cnt", mispredict_cnt, 32'd6);

    // 5. flush with a simultaneous taken update
    flush_all = 1'b1;
    upd(1'b1, 32'h200, 1'b1, 32'h280, 1'b0, 32'h204);
    tick();
    flush_all = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("flush_80", 32'h80, 1'b0, 32'h84);
    look("flush_200", 32'h200, 1'b0, 32'h204);
    check("flush_cnt", mispredict_cnt, 32'd7);
    upd(1'b1, 32'h80, 1'b1, 32'h190, 1'b0, 32'h84);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("realloc", 32'h80, 1'b1, 32'h190);

    // 6. saturation of the statistics counter, then reset mid-update
    force dut.mispredictCnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.mispredictCnt_r;
    upd(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h190);
    #1;
    check("sat_pre", mispredict_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_hold", mispredict_cnt, 32'hFFFF_FFFF);
    upd(1'b1, 32'h80, 1'b1, 32'h1A0, 1'b0, 32'h84);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cnt", mispredict_cnt, 32'd0);
    look("rst_mid_lk", 32'h80, 1'b0, 32'h84);
    tick();
    check("rst_hold_cnt", mispredict_cnt, 32'd0);
    look("rst_hold_lk", 32'h80, 1'b0, 32'h84);
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();
    look("post_rst", 32'h40, 1'b0, 32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
